sync_updown_count_n: RTL and testbench

SYNC_UPDOWN_COUNT_N -- requirements
Module: sync_updown_count_n

---
 rtl/sync_updown_count_n_if.sv | 17 +
 rtl/sync_updown_count_n.sv | 73 +++++++
 tb/tb_sync_updown_count_n.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sync_updown_count_n_if.sv
// Control and status bundle for the modulo-N up/down counter.
// The host side drives en/up_dn/load/d; the counter side returns q, qbar, tc and wrap.
interface sync_updown_count_n_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;
  logic             wrap;

  modport master (output en, up_dn, load, d, input q, qbar, tc, wrap);
  modport slave  (input en, up_dn, load, d, output q, qbar, tc, wrap);
endinterface

// File: rtl/sync_updown_count_n.sv
// Synchronous modulo-MODULUS up/down counter with clamped parallel load,
// optional saturation, terminal-count flag and registered rollover pulse.
module sync_updown_count_n #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  sync_updown_count_n_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic [WIDTH-1:0] load_val;
  logic             at_max;
  logic             at_min;

  // Clamp only exists when d can actually exceed the top of the range.
  generate
    if (64'(MODULUS) < (64'd1 << WIDTH)) begin : g_clamp
      always_comb load_val = (bus.d > MAX) ? MAX : bus.d;
    end else begin : g_full
      always_comb load_val = bus.d;
    end
  endgenerate

  assign at_max = (q_r == MAX);
  assign at_min = (q_r == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
    end else if (bus.load) begin
      q_r    <= load_val;
      wrap_r <= 1'b0;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (!at_max) begin
          q_r    <= q_r + 1'b1;
          wrap_r <= 1'b0;
        end else if (SATURATE) begin
          wrap_r <= 1'b0;
        end else begin
          q_r    <= '0;
          wrap_r <= 1'b1;
        end
      end else begin
        if (!at_min) begin
          q_r    <= q_r - 1'b1;
          wrap_r <= 1'b0;
        end else if (SATURATE) begin
          wrap_r <= 1'b0;
        end else begin
          q_r    <= MAX;
          wrap_r <= 1'b1;
        end
      end
    end else begin
      wrap_r <= 1'b0;
    end
  end

  assign bus.q    = q_r;
  assign bus.qbar = ~q_r;
  assign bus.wrap = wrap_r;
  // Terminal count deliberately ignores load.
  assign bus.tc   = bus.en & ((bus.up_dn & at_max) | (~bus.up_dn & at_min));

endmodule

// File: tb/tb_sync_updown_count_n.sv
// Self-checking bench: four counter variants driven in lockstep and compared
// against a modular-arithmetic reference model, directed tables and random stimulus.
module tb_sync_updown_count_n;

  logic       clk;
  logic       rst;
  logic       en_s, up_s, load_s;
  logic [3:0] d_s;

  int checks = 0;
  int errors = 0;

  sync_updown_count_n_if #(.WIDTH(4)) b0 ();
  sync_updown_count_n_if #(.WIDTH(4)) b1 ();
  sync_updown_count_n_if #(.WIDTH(4)) b2 ();
  sync_updown_count_n_if #(.WIDTH(4)) b3 ();

  sync_updown_count_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_m10  (.clk(clk), .rst(rst), .bus(b0));
  sync_updown_count_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_m10s (.clk(clk), .rst(rst), .bus(b1));
  sync_updown_count_n                                             u_def  (.clk(clk), .rst(rst), .bus(b2));
  sync_updown_count_n #(.WIDTH(4), .MODULUS(2),  .SATURATE(1'b0)) u_m2   (.clk(clk), .rst(rst), .bus(b3));

  assign {b0.en, b0.up_dn, b0.load, b0.d} = {en_s, up_s, load_s, d_s};
  assign {b1.en, b1.up_dn, b1.load, b1.d} = {en_s, up_s, load_s, d_s};
  assign {b2.en, b2.up_dn, b2.load, b2.d} = {en_s, up_s, load_s, d_s};
  assign {b3.en, b3.up_dn, b3.load, b3.d} = {en_s, up_s, load_s, d_s};

  logic [3:0] aq[4];
  logic [3:0] aqb[4];
  logic       atc[4];
  logic       aw[4];
  assign aq[0] = b0.q; assign aqb[0] = b0.qbar; assign atc[0] = b0.tc; assign aw[0] = b0.wrap;
  assign aq[1] = b1.q; assign aqb[1] = b1.qbar; assign atc[1] = b1.tc; assign aw[1] = b1.wrap;
  assign aq[2] = b2.q; assign aqb[2] = b2.qbar; assign atc[2] = b2.tc; assign aw[2] = b2.wrap;
  assign aq[3] = b3.q; assign aqb[3] = b3.qbar; assign atc[3] = b3.tc; assign aw[3] = b3.wrap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: count value as an integer in [0, mod), rollover by modular arithmetic.
  int mod_c[4] = '{10, 10, 16, 2};
  bit sat_c[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  int mq[4];
  bit mw[4];

  typedef struct {
    bit       en;
    bit       up;
    bit       ld;
    bit [3:0] d;
    int       q;
    bit       w;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d at %0t: got %0d expected %0d", name, idx, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i] = 0;
      mw[i] = 1'b0;
    end
  endtask

  function automatic bit model_tc(input int i, input bit e, input bit u);
    return e && ((u && mq[i] == mod_c[i] - 1) || (!u && mq[i] == 0));
  endfunction

  task automatic model_edge(input bit e, input bit u, input bit l, input int dd);
    int target;
    for (int i = 0; i < 4; i++) begin
      if (l) begin
        mq[i] = (dd > mod_c[i] - 1) ? mod_c[i] - 1 : dd;
        mw[i] = 1'b0;
      end else if (e) begin
        target = mq[i] + (u ? 1 : -1);
        if (target >= 0 && target < mod_c[i]) begin
          mq[i] = target;
          mw[i] = 1'b0;
        end else if (sat_c[i]) begin
          mw[i] = 1'b0;
        end else begin
          mq[i] = (target + mod_c[i]) % mod_c[i];
          mw[i] = 1'b1;
        end
      end else begin
        mw[i] = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 4; i++) begin
      chk("q", i, int'(aq[i]), mq[i]);
      chk("qbar", i, int'(aqb[i]), (~mq[i]) & 15);
      chk("wrap", i, int'(aw[i]), int'(mw[i]));
    end
  endtask

  task automatic step(input bit e, input bit u, input bit l, input bit [3:0] dd);
    @(negedge clk);
    en_s = e; up_s = u; load_s = l; d_s = dd;
    #1;
    for (int i = 0; i < 4; i++) chk("tc", i, int'(atc[i]), int'(model_tc(i, e, u)));
    @(posedge clk);
    model_edge(e, u, l, int'(dd));
    #1;
    check_outputs();
  endtask

  initial begin
    rst = 1'b0; en_s = 1'b0; up_s = 1'b0; load_s = 1'b0; d_s = 4'd0;
    #2 rst = 1'b1;
    model_reset();
    #1 check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Directed table; expected q/wrap are for the MODULUS=10 wrapping instance.
    for (int k = 1; k <= 9; k++) tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd0, k, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  2, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 4'd13, 9, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 4'd5,  5, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 4'd3,  3, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  4, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'd0,  4, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'd0,  4, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  5, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 4'd0,  4, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 4'd0,  0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 4'd0,  9, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 4'd0,  8, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 4'd15, 9, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  0, 1'b1});

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].up, tbl[i].ld, tbl[i].d);
      chk("tbl_q", i, int'(aq[0]), tbl[i].q);
      chk("tbl_wrap", i, int'(aw[0]), int'(tbl[i].w));
    end
    chk("def_15_to_0", 2, int'(aq[2]), 0);
    chk("def_wrap", 2, int'(aw[2]), 1);

    // Asynchronous reset between edges with q=7.
    step(1'b0, 1'b1, 1'b1, 4'd7);
    chk("pre_rst_q", 0, int'(aq[0]), 7);
    @(negedge clk);
    en_s = 1'b0; load_s = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_q", 0, int'(aq[0]), 0);
    chk("async_qbar", 0, int'(aqb[0]), 15);
    chk("async_wrap", 0, int'(aw[0]), 0);
    model_reset();
    check_outputs();
    // Inputs ignored while reset is held; tc still reflects q=0.
    en_s = 1'b1; up_s = 1'b0; load_s = 1'b1; d_s = 4'd5;
    #1;
    for (int i = 0; i < 4; i++) chk("tc_in_rst", i, int'(atc[i]), 1);
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0; en_s = 1'b0; load_s = 1'b0;

    // MODULUS=2 back-to-back rollovers: down 0->1 then up 1->0.
    step(1'b1, 1'b0, 1'b0, 4'd0);
    chk("m2_down_wrap", 3, int'(aw[3]), 1);
    chk("m2_down_q", 3, int'(aq[3]), 1);
    step(1'b1, 1'b1, 1'b0, 4'd0);
    chk("m2_up_wrap", 3, int'(aw[3]), 1);
    chk("m2_up_q", 3, int'(aq[3]), 0);
    chk("sat_hold_q", 1, int'(aq[1]), 1);

    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
